// File: rtl/gpio_freq_monitor_pkg.sv
// Shared types and helpers for the GPIO frequency monitor.
// Contents: FSM state encoding and a width-generic saturating increment.
package gpio_freq_monitor_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int unsigned SAT_MAX_WIDTH = 64;

  // Increments value but never exceeds all-ones at the given width (width <= 64).
  function automatic logic [SAT_MAX_WIDTH-1:0] sat_inc(
    input logic [SAT_MAX_WIDTH-1:0] value,
    input int unsigned              width
  );
    logic [SAT_MAX_WIDTH-1:0] limit;
    if (width >= SAT_MAX_WIDTH)
      limit = '1;
    else
      limit = (SAT_MAX_WIDTH'(1) << width) - SAT_MAX_WIDTH'(1);
    return (value >= limit) ? limit : value + SAT_MAX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/signal_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous input bit.
// Shared by the GPIO input blocks; chain resets to 0.
module signal_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      chain <= '0;
    else
      chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_freq_monitor.sv
// Measures edges per gate window, edge-to-edge period and loss of signal
// for an asynchronous single-ended input, all in the clk domain.
module gpio_freq_monitor
  import gpio_freq_monitor_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 156250,
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned LOS_CYCLES  = 65536,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sig_in,
  input  logic                   en,
  output logic                   freq_valid,
  output logic [COUNT_WIDTH-1:0] freq_count,
  output logic                   freq_overflow,
  output logic                   period_valid,
  output logic [COUNT_WIDTH-1:0] period_cycles,
  output logic                   los
);

  localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
  localparam int unsigned LOS_W  = $clog2(LOS_CYCLES + 1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [LOS_W-1:0]  LOS_LIMIT = LOS_W'(LOS_CYCLES);

  state_t state, state_next;
  logic   active;
  logic   sync, hist, rise;
  logic   gate_last;
  logic   edge_sat, first_seen;
  logic [GATE_W-1:0]      gate_cnt;
  logic [COUNT_WIDTH-1:0] edge_cnt, edge_inc;
  logic [COUNT_WIDTH-1:0] period_cnt, period_inc;
  logic [LOS_W-1:0]       los_cnt, los_inc;

  signal_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (sig_in),
    .q  (sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hist  <= 1'b0;
    end else begin
      state <= state_next;
      hist  <= sync;
    end
  end

  assign rise = sync & ~hist;

  // en=0 in MEASURE already counts as leaving, so nothing is recorded that cycle.
  always_comb begin
    state_next = state;
    active     = 1'b0;
    unique case (state)
      IDLE:    if (en) state_next = MEASURE;
      MEASURE: begin
        if (en) active = 1'b1;
        else    state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gate_last  = (gate_cnt == GATE_LAST);
    edge_inc   = COUNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(edge_cnt), COUNT_WIDTH));
    period_inc = COUNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(period_cnt), COUNT_WIDTH));
    los_inc    = (los_cnt == LOS_LIMIT) ? los_cnt : los_cnt + LOS_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_cnt      <= '0;
      edge_cnt      <= '0;
      edge_sat      <= 1'b0;
      period_cnt    <= '0;
      first_seen    <= 1'b0;
      los_cnt       <= '0;
      freq_valid    <= 1'b0;
      freq_count    <= '0;
      freq_overflow <= 1'b0;
      period_valid  <= 1'b0;
      period_cycles <= '0;
      los           <= 1'b0;
    end else if (!active) begin
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      edge_sat     <= 1'b0;
      period_cnt   <= '0;
      first_seen   <= 1'b0;
      los_cnt      <= '0;
      freq_valid   <= 1'b0;
      period_valid <= 1'b0;
      los          <= 1'b0;
    end else begin
      freq_valid   <= 1'b0;
      period_valid <= 1'b0;

      // A rise on the terminal cycle belongs to the closing window.
      if (gate_last) begin
        gate_cnt      <= '0;
        edge_cnt      <= '0;
        edge_sat      <= 1'b0;
        freq_count    <= rise ? edge_inc : edge_cnt;
        freq_overflow <= edge_sat | (rise & (edge_cnt == '1));
        freq_valid    <= 1'b1;
      end else begin
        gate_cnt <= gate_cnt + GATE_W'(1);
        if (rise) begin
          edge_cnt <= edge_inc;
          if (edge_cnt == '1) edge_sat <= 1'b1;
        end
      end

      // los_cnt restarts at 1 so the rise cycle itself counts as elapsed.
      if (rise) begin
        if (first_seen) begin
          period_cycles <= period_inc;
          period_valid  <= 1'b1;
        end
        period_cnt <= '0;
        first_seen <= 1'b1;
        los_cnt    <= LOS_W'(1);
        los        <= 1'b0;
      end else begin
        period_cnt <= period_inc;
        los_cnt    <= los_inc;
        los        <= (los_inc == LOS_LIMIT);
      end
    end
  end

endmodule

// File: tb/tb_gpio_freq_monitor.sv
// Directed bench for gpio_freq_monitor: 32-bit and 4-bit count instances
// share clk/rst/en/sig_in; expectations are hand-derived cycle offsets.
module tb_gpio_freq_monitor;

  logic clk, rst, en, sig_in;

  logic        fv, fo, pv, los;
  logic [31:0] fc, pc;
  logic        s_fv, s_fo, s_pv, s_los;
  logic [3:0]  s_fc, s_pc;

  gpio_freq_monitor #(
    .GATE_CYCLES(100), .COUNT_WIDTH(32), .LOS_CYCLES(50), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .en(en),
    .freq_valid(fv), .freq_count(fc), .freq_overflow(fo),
    .period_valid(pv), .period_cycles(pc), .los(los)
  );

  gpio_freq_monitor #(
    .GATE_CYCLES(100), .COUNT_WIDTH(4), .LOS_CYCLES(50), .SYNC_STAGES(2)
  ) dut_small (
    .clk(clk), .rst(rst), .sig_in(sig_in), .en(en),
    .freq_valid(s_fv), .freq_count(s_fc), .freq_overflow(s_fo),
    .period_valid(s_pv), .period_cycles(s_pc), .los(s_los)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int wave_per = 0, wave_hi = 0, ph = 0;
  int fv_n, fv_first, fv_last, fv_sum, fv_in;
  int pv_n, pv_first, pv_match, exp_period;
  int pv_last = 0, los_hi = 0, los_rise = 0, los_fall = 0;
  logic los_prev = 1'b0;
  bit fv_now;

  task automatic check(input string tag, input int observed, input int expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clear_stats();
    fv_n = 0; fv_first = 0; fv_last = 0; fv_sum = 0; fv_in = 0;
    pv_n = 0; pv_first = 0; pv_match = 0; los_hi = 0;
  endtask

  task automatic start_wave(input int per, input int hi);
    wave_per = per; wave_hi = hi; ph = 1; sig_in = 1'b1;
  endtask

  // One clock: sample just after the edge, then advance the input waveform.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    fv_now = fv;
    if (fv) begin
      fv_n++;
      if (fv_n == 1) fv_first = cyc;
      fv_last = cyc;
      fv_sum += int'(fc);
      if (fc == 32'd14 || fc == 32'd15) fv_in++;
    end
    if (pv) begin
      pv_n++;
      if (pv_n == 1) pv_first = cyc;
      pv_last = cyc;
      if (int'(pc) == exp_period) pv_match++;
    end
    if (los) los_hi++;
    if (los && !los_prev) los_rise = cyc;
    if (!los && los_prev) los_fall = cyc;
    los_prev = los;
    if (wave_per != 0) begin
      sig_in = (ph < wave_hi);
      ph = (ph + 1 == wave_per) ? 0 : ph + 1;
    end
  endtask

  int mark;
  bit found;

  initial begin
    rst = 1'b1; en = 1'b0; sig_in = 1'b0;
    exp_period = 0;
    clear_stats();

    // Reset state
    repeat (3) step();
    check("rst_flags", int'({fv, fo, pv, los}), 0);
    check("rst_freq_count", int'(fc), 0);
    check("rst_period", int'(pc), 0);
    check("rst_small_flags", int'({s_fv, s_fo, s_pv, s_los}), 0);
    check("rst_small_counts", int'({s_fc, s_pc}), 0);
    rst = 1'b0;
    repeat (2) step();
    check("idle_los", int'(los), 0);

    // Period-10 square wave
    en = 1'b1; start_wave(10, 5); clear_stats(); mark = cyc; exp_period = 10;
    repeat (305) step();
    check("p10_first_fv_latency", fv_first - mark, 101);
    check("p10_fv_count", fv_n, 3);
    check("p10_fv_spacing", fv_last - fv_first, 200);
    check("p10_freq_count", int'(fc), 10);
    check("p10_pv_count", pv_n, 30);
    check("p10_pv_value_ok", pv_match, 30);
    check("p10_los_cycles", los_hi, 0);
    check("p10_small_count", int'(s_fc), 10);
    check("p10_small_ovf", int'(s_fo), 0);

    // Period-7 wave: seven windows cover exactly 100 periods
    start_wave(7, 3);
    repeat (200) step();
    clear_stats(); exp_period = 7;
    repeat (700) step();
    check("p7_fv_count", fv_n, 7);
    check("p7_fv_sum", fv_sum, 100);
    check("p7_fv_14_or_15", fv_in, 7);
    check("p7_pv_count", pv_n, 100);
    check("p7_pv_value_ok", pv_match, 100);

    // Period-2 wave: 50 edges per window
    start_wave(2, 1);
    repeat (250) step();
    check("p2_freq_count", int'(fc), 50);
    check("p2_ovf", int'(fo), 0);
    check("p2_period", int'(pc), 2);
    check("p2_small_count_sat", int'(s_fc), 15);
    check("p2_small_ovf", int'(s_fo), 1);
    check("p2_small_period", int'(s_pc), 2);

    // Input stopped low: LOS and empty windows
    wave_per = 0; sig_in = 1'b0;
    repeat (250) step();
    check("los_delay", los_rise - pv_last, 49);
    check("los_level", int'(los), 1);
    check("empty_freq_count", int'(fc), 0);
    check("empty_small_count", int'(s_fc), 0);
    check("empty_small_ovf", int'(s_fo), 0);
    mark = cyc; sig_in = 1'b1;
    repeat (5) step();
    check("los_clear_cycle", los_fall - mark, 3);
    check("edge_pv_cycle", pv_last - mark, 3);
    check("los_after_edge", int'(los), 0);
    check("small_period_sat", int'(s_pc), 15);

    // en dropped 60 cycles into a window, then restored
    start_wave(10, 5);
    repeat (250) step();
    found = 1'b0;
    for (int i = 0; i < 150 && !found; i++) begin
      step();
      if (fv_now) found = 1'b1;
    end
    check("window_found", int'(found), 1);
    repeat (60) step();
    en = 1'b0; clear_stats();
    repeat (30) step();
    check("idle_no_fv", fv_n, 0);
    check("idle_no_pv", pv_n, 0);
    check("idle_los_low", los_hi, 0);
    check("idle_held_count", int'(fc), 10);
    check("idle_held_period", int'(pc), 10);
    check("idle_held_ovf", int'(fo), 0);
    check("idle_held_small", int'(s_fc), 10);
    en = 1'b1; mark = cyc; clear_stats();
    repeat (105) step();
    check("reentry_fv_latency", fv_first - mark, 101);
    check("reentry_fv_count", fv_n, 1);

    // Asynchronous reset mid-window and mid-period
    repeat (37) step();
    rst = 1'b1; wave_per = 0; sig_in = 1'b0;
    #1;
    check("async_rst_flags", int'({fv, fo, pv, los}), 0);
    check("async_rst_count", int'(fc), 0);
    check("async_rst_period", int'(pc), 0);
    check("async_rst_small", int'({s_fc, s_pc}), 0);
    repeat (3) step();
    rst = 1'b0; start_wave(10, 5); mark = cyc; clear_stats();
    repeat (20) step();
    check("post_rst_first_pv", pv_first - mark, 13);
    check("post_rst_pv_count", pv_n, 1);
    check("post_rst_no_fv", fv_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
